// File: rtl/branch_pkg.sv
// ----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch execution stage.
//   - Bit positions of the branch control field (COND / JAL / JALR).
//   - funct3 encodings of the RISC-V conditional branches.
//   - Output buffer state type (EMPTY / FULL).
//   - Packed struct describing one buffered, resolved branch.
// The struct fields are sized by PKG_WIDTH / PKG_ROB. These are also the
// default values of the WIDTH / ROB parameters of branch_exec_unit, so the
// two must be changed together.
// ----------------------------------------------------------------------------
package branch_pkg;

    localparam int PKG_WIDTH   = 31;
    localparam int PKG_ROB     = 2;
    localparam int PKG_C_WIDTH = 7;

    // Positions of the control bits inside instrInfo; [2:0] carries funct3.
    localparam int COND_BIT = 3;
    localparam int JAL_BIT  = 4;
    localparam int JALR_BIT = 5;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bufState_t;

    typedef struct packed {
        logic [PKG_WIDTH:0] result;
        logic [PKG_ROB:0]   rob;
        logic [PKG_WIDTH:0] correctPC;
        logic               taken;
        logic               mispredict;
    } branchEntry_t;

endpackage

// File: rtl/branch_compare.sv
// ----------------------------------------------------------------------------
// branch_compare
// Purely combinational condition evaluator for conditional branches.
// Ports:
//   i_src1, i_src2 : signed operands (WIDTH+1 bits)
//   i_funct3       : branch funct3 selecting the comparison
//   o_cond         : 1 when the branch condition holds; the unused funct3
//                    codes 010/011 always give 0 (not taken)
// ----------------------------------------------------------------------------
module branch_compare
    import branch_pkg::*;
#(
    parameter int WIDTH = 31
) (
    input  logic signed [WIDTH:0] i_src1,
    input  logic signed [WIDTH:0] i_src2,
    input  logic        [2:0]     i_funct3,
    output logic                  o_cond
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    // The three primitive relations every branch is built from; both operands
    // are declared signed, so w_lt is a two's-complement compare and w_ltu
    // reinterprets the same bits as unsigned.
    assign w_eq  = (i_src1 == i_src2);
    assign w_lt  = (i_src1 < i_src2);
    assign w_ltu = ($unsigned(i_src1) < $unsigned(i_src2));

    // The GE variants are simply the negation of the matching LT relation.
    always_comb begin
        o_cond = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_cond = w_eq;
            F3_BNE:  o_cond = ~w_eq;
            F3_BLT:  o_cond = w_lt;
            F3_BGE:  o_cond = ~w_lt;
            F3_BLTU: o_cond = w_ltu;
            F3_BGEU: o_cond = ~w_ltu;
            default: o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_exec_unit.sv
// ----------------------------------------------------------------------------
// branch_exec_unit
// Single-cycle branch execution stage with a one-deep result buffer that
// holds the resolved branch until the CDB arbiter grants the broadcast.
// Ports:
//   clk, globalReset      : clock, synchronous active-high reset
//   execute               : granted RS entry is issued this cycle
//   src1, src2            : signed operands
//   instrInfo             : [2:0] funct3, [3] COND, [4] JAL, [5] JALR
//   instrRob              : ROB tag of the issued instruction
//   predictedAddress      : next PC predicted at fetch
//   targetAddress         : branch/JAL target, or the JALR immediate
//   branchResult          : sequential PC (PC+4)
//   flush                 : ROB pipeline clear, drops buffer and any issue
//   cdbGrant              : arbiter grants the broadcast this cycle
//   exReady               : an issue can be accepted this cycle
//   cdbReq                : buffer holds a result awaiting broadcast
//   cdbResult, cdbRob     : writeback value (link PC or 0) and its tag
//   mispredict, correctPC : resolved next PC and its mismatch vs prediction
//   taken                 : resolved direction
// Optional build macro BRANCH_STATS_EN adds saturating 32-bit outputs
// branchCount / mispredictCount counting granted broadcasts; they are cleared
// by globalReset only.
// ----------------------------------------------------------------------------
module branch_exec_unit
    import branch_pkg::*;
#(
    parameter int WIDTH   = PKG_WIDTH,
    parameter int ROB     = PKG_ROB,
    parameter int C_WIDTH = PKG_C_WIDTH
) (
    input  logic                  clk,
    input  logic                  globalReset,
    input  logic                  execute,
    input  logic signed [WIDTH:0] src1,
    input  logic signed [WIDTH:0] src2,
    input  logic [C_WIDTH:0]      instrInfo,
    input  logic [ROB:0]          instrRob,
    input  logic [WIDTH:0]        predictedAddress,
    input  logic [WIDTH:0]        targetAddress,
    input  logic [WIDTH:0]        branchResult,
    input  logic                  flush,
    input  logic                  cdbGrant,
    output logic                  exReady,
    output logic                  cdbReq,
    output logic [WIDTH:0]        cdbResult,
    output logic [ROB:0]          cdbRob,
    output logic                  mispredict,
    output logic [WIDTH:0]        correctPC,
`ifdef BRANCH_STATS_EN
    output logic [31:0]           branchCount,
    output logic [31:0]           mispredictCount,
`endif
    output logic                  taken
);

    bufState_t    r_state;
    branchEntry_t r_entry;
    branchEntry_t w_next;
    logic         w_cond;
    logic [WIDTH:0] w_jalrSum;
    logic         w_unusedBits;

    // instrInfo bits above JALR are reserved and deliberately ignored.
    assign w_unusedBits = &{1'b0, instrInfo[C_WIDTH:JALR_BIT+1]};

    branch_compare #(
        .WIDTH (WIDTH)
    ) u_compare (
        .i_src1   (src1),
        .i_src2   (src2),
        .i_funct3 (instrInfo[2:0]),
        .o_cond   (w_cond)
    );

    // JALR target wraps naturally at the datapath width.
    assign w_jalrSum = $unsigned(src1) + targetAddress;

    // Resolve the issued branch into the form it will be buffered in. If more
    // than one control bit is set, JALR wins over JAL, which wins over COND;
    // with none set the op falls through sequentially as not taken.
    always_comb begin
        w_next     = '0;
        w_next.rob = instrRob;
        if (instrInfo[JALR_BIT]) begin
            w_next.taken     = 1'b1;
            w_next.correctPC = {w_jalrSum[WIDTH:1], 1'b0};
            w_next.result    = branchResult;
        end else if (instrInfo[JAL_BIT]) begin
            w_next.taken     = 1'b1;
            w_next.correctPC = targetAddress;
            w_next.result    = branchResult;
        end else if (instrInfo[COND_BIT]) begin
            w_next.taken     = w_cond;
            w_next.correctPC = w_cond ? targetAddress : branchResult;
        end else begin
            w_next.taken     = 1'b0;
            w_next.correctPC = branchResult;
        end
        w_next.mispredict = (w_next.correctPC != predictedAddress);
    end

    // A new op can be taken when the buffer is empty, or when the current
    // occupant leaves this very cycle, which gives one result per cycle.
    assign exReady = (r_state == EMPTY) || cdbGrant;

    // Buffer state machine. Reset/flush clears everything and overrides any
    // coinciding issue or grant. An issue while not ready is ignored, and a
    // grant while empty has nothing to act on. Draining zeroes the stored
    // fields so stale data never sits on the outputs.
    always_ff @(posedge clk) begin
        if (globalReset || flush) begin
            r_state <= EMPTY;
            r_entry <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (execute) begin
                        r_state <= FULL;
                        r_entry <= w_next;
                    end
                end
                FULL: begin
                    if (cdbGrant) begin
                        if (execute) begin
                            r_entry <= w_next;
                        end else begin
                            r_state <= EMPTY;
                            r_entry <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_entry <= '0;
                end
            endcase
        end
    end

    assign cdbReq     = (r_state == FULL);
    assign cdbResult  = r_entry.result;
    assign cdbRob     = r_entry.rob;
    assign mispredict = r_entry.mispredict;
    assign correctPC  = r_entry.correctPC;
    assign taken      = r_entry.taken;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_branchCount;
    logic [31:0] r_mispredictCount;

    // Statistics survive a flush so they reflect the whole run. A grant that
    // coincides with a flush is not counted because the flush discards the
    // buffered result before it is broadcast. Both counters saturate.
    always_ff @(posedge clk) begin
        if (globalReset) begin
            r_branchCount     <= '0;
            r_mispredictCount <= '0;
        end else if (!flush && (r_state == FULL) && cdbGrant) begin
            if (r_branchCount != '1) begin
                r_branchCount <= r_branchCount + 32'd1;
            end
            if (r_entry.mispredict && (r_mispredictCount != '1)) begin
                r_mispredictCount <= r_mispredictCount + 32'd1;
            end
        end
    end

    assign branchCount     = r_branchCount;
    assign mispredictCount = r_mispredictCount;
`endif

    // Upstream must never issue into an occupied buffer that is not draining.
    property pNoIssueWhenBusy;
        @(posedge clk) disable iff (globalReset || flush)
            execute |-> exReady;
    endproperty
    aNoIssueWhenBusy: assert property (pNoIssueWhenBusy);

endmodule

// File: tb/tb_branch_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_exec_unit
// Self-checking bench for branch_exec_unit: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural model of the
// buffered branch result. Counter checks are compiled in with BRANCH_STATS_EN.
// ----------------------------------------------------------------------------
module tb_branch_exec_unit;

    logic        clk = 1'b0;
    logic        globalReset;
    logic        execute;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [7:0]  instrInfo;
    logic [2:0]  instrRob;
    logic [31:0] predictedAddress;
    logic [31:0] targetAddress;
    logic [31:0] branchResult;
    logic        flush;
    logic        cdbGrant;
    logic        exReady;
    logic        cdbReq;
    logic [31:0] cdbResult;
    logic [2:0]  cdbRob;
    logic        mispredict;
    logic [31:0] correctPC;
    logic        taken;
`ifdef BRANCH_STATS_EN
    logic [31:0] branchCount;
    logic [31:0] mispredictCount;
`endif

    always #5 clk = ~clk;

    branch_exec_unit dut (
        .clk              (clk),
        .globalReset      (globalReset),
        .execute          (execute),
        .src1             (src1),
        .src2             (src2),
        .instrInfo        (instrInfo),
        .instrRob         (instrRob),
        .predictedAddress (predictedAddress),
        .targetAddress    (targetAddress),
        .branchResult     (branchResult),
        .flush            (flush),
        .cdbGrant         (cdbGrant),
        .exReady          (exReady),
        .cdbReq           (cdbReq),
        .cdbResult        (cdbResult),
        .cdbRob           (cdbRob),
        .mispredict       (mispredict),
        .correctPC        (correctPC),
`ifdef BRANCH_STATS_EN
        .branchCount      (branchCount),
        .mispredictCount  (mispredictCount),
`endif
        .taken            (taken)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  rob;
        logic [31:0] pc;
        logic        tk;
        logic        mp;
    } expEntry_t;

    // Behavioural model state: is a result waiting, what it is, and whether
    // the outputs are known to be cleared (after reset or flush).
    bit          mFull;
    bit          mZero;
    expEntry_t   mEntry;
    int unsigned mBranch;
    int unsigned mMisp;

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Branch semantics stated directly from the ISA rules.
    function automatic expEntry_t resolve(input logic [7:0] info, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] tgt,
                                          input logic [31:0] seq, input logic [31:0] pred,
                                          input logic [2:0] rob);
        expEntry_t   e;
        int          sa = a;
        int          sb = b;
        int unsigned ua = a;
        int unsigned ub = b;
        bit          cond;
        case (info[2:0])
            3'd0:    cond = (sa == sb);
            3'd1:    cond = (sa != sb);
            3'd4:    cond = (sa <  sb);
            3'd5:    cond = (sa >= sb);
            3'd6:    cond = (ua <  ub);
            3'd7:    cond = (ua >= ub);
            default: cond = 1'b0;
        endcase
        e     = '0;
        e.rob = rob;
        if (info[5]) begin
            e.tk  = 1'b1;
            e.pc  = (a + tgt) & 32'hFFFF_FFFE;
            e.res = seq;
        end else if (info[4]) begin
            e.tk  = 1'b1;
            e.pc  = tgt;
            e.res = seq;
        end else if (info[3]) begin
            e.tk  = cond;
            e.pc  = cond ? tgt : seq;
            e.res = 32'd0;
        end else begin
            e.tk  = 1'b0;
            e.pc  = seq;
            e.res = 32'd0;
        end
        e.mp = (e.pc != pred);
        return e;
    endfunction

    task automatic applyStimulus(input logic ex, input logic [7:0] info,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] tgt, input logic [31:0] seq,
                                 input logic [31:0] pred, input logic [2:0] rob,
                                 input logic grant, input logic fl);
        execute          = ex;
        instrInfo        = info;
        src1             = a;
        src2             = b;
        targetAddress    = tgt;
        branchResult     = seq;
        predictedAddress = pred;
        instrRob         = rob;
        cdbGrant         = grant;
        flush            = fl;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_cdbReq"}, {31'd0, cdbReq}, {31'd0, mFull});
        if (mFull) begin
            checkOutput({tag, "_cdbResult"},  cdbResult, mEntry.res);
            checkOutput({tag, "_cdbRob"},     {29'd0, cdbRob}, {29'd0, mEntry.rob});
            checkOutput({tag, "_correctPC"},  correctPC, mEntry.pc);
            checkOutput({tag, "_taken"},      {31'd0, taken}, {31'd0, mEntry.tk});
            checkOutput({tag, "_mispredict"}, {31'd0, mispredict}, {31'd0, mEntry.mp});
        end else if (mZero) begin
            checkOutput({tag, "_zeroFields"},
                        cdbResult | correctPC | {29'd0, cdbRob} | {31'd0, taken} | {31'd0, mispredict},
                        32'd0);
        end
`ifdef BRANCH_STATS_EN
        checkOutput({tag, "_branchCount"},     branchCount, mBranch);
        checkOutput({tag, "_mispredictCount"}, mispredictCount, mMisp);
`endif
    endtask

    // One clock: check the combinational ready, advance the model with the
    // inputs currently applied, then check registered outputs after the edge.
    task automatic tick(input string tag);
        bit expReady;
        #1;
        expReady = !mFull || cdbGrant;
        checkOutput({tag, "_exReady"}, {31'd0, exReady}, {31'd0, expReady});
        if (globalReset || flush) begin
            mFull = 1'b0;
            mZero = 1'b1;
            if (globalReset) begin
                mBranch = 0;
                mMisp   = 0;
            end
        end else begin
            if (mFull && cdbGrant) begin
                if (mBranch != 32'hFFFF_FFFF) mBranch++;
                if (mEntry.mp && mMisp != 32'hFFFF_FFFF) mMisp++;
            end
            if (execute && expReady) begin
                mEntry = resolve(instrInfo, src1, src2, targetAddress, branchResult,
                                 predictedAddress, instrRob);
                mFull  = 1'b1;
                mZero  = 1'b0;
            end else if (mFull && cdbGrant) begin
                mFull = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic idle(input string tag);
        applyStimulus(1'b0, 8'h00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
        tick(tag);
    endtask

    task automatic doReset(input string tag);
        globalReset = 1'b1;
        applyStimulus(1'b0, 8'h00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
        tick(tag);
        globalReset = 1'b0;
    endtask

    initial begin
        logic [7:0]  info;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] tgt;
        logic [31:0] seq;
        logic [31:0] pred;
        logic        g;
        logic        ex;
        logic        fl;

        mFull   = 1'b0;
        mZero   = 1'b1;
        mEntry  = '0;
        mBranch = 0;
        mMisp   = 0;
        globalReset = 1'b1;
        applyStimulus(1'b0, 8'h00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        doReset("reset");

        // BEQ taken against a sequential prediction.
        applyStimulus(1'b1, 8'h08, 32'd5, 32'd5, 32'h100, 32'h84, 32'h84, 3'd3, 1'b0, 1'b0);
        tick("beq");
        checkOutput("beq_fixedPC", correctPC, 32'h100);
        checkOutput("beq_fixedMisp", {31'd0, mispredict}, 32'd1);
        applyStimulus(1'b0, 8'h00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0);
        tick("beqDrain");

        // Signed versus unsigned less-than on -1 vs 1, issued back to back.
        applyStimulus(1'b1, 8'h0C, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h44, 32'h44, 3'd1, 1'b0, 1'b0);
        tick("blt");
        checkOutput("blt_fixedTaken", {31'd0, taken}, 32'd1);
        applyStimulus(1'b1, 8'h0E, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h44, 32'h44, 3'd2, 1'b1, 1'b0);
        tick("bltu");
        checkOutput("bltu_fixedTaken", {31'd0, taken}, 32'd0);
        checkOutput("bltu_fixedPC", correctPC, 32'h44);

        // JALR with odd sum: low bit cleared, link value on the CDB.
        applyStimulus(1'b1, 8'h20, 32'h1003, 32'd0, 32'h4, 32'h20, 32'h1006, 3'd5, 1'b1, 1'b0);
        tick("jalr");
        checkOutput("jalr_fixedPC", correctPC, 32'h1006);
        checkOutput("jalr_fixedResult", cdbResult, 32'h20);
        applyStimulus(1'b0, 8'h00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0);
        tick("jalrDrain");

        // Hold for three cycles without grant, then replace in the same cycle.
        applyStimulus(1'b1, 8'h10, 32'd0, 32'd0, 32'h400, 32'h10, 32'h10, 3'd6, 1'b0, 1'b0);
        tick("holdIssue");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h09, $urandom, $urandom, $urandom, $urandom, $urandom,
                          3'($urandom), 1'b0, 1'b0);
            tick("hold");
        end
        applyStimulus(1'b1, 8'h09, 32'd7, 32'd8, 32'h500, 32'h14, 32'h14, 3'd2, 1'b1, 1'b0);
        tick("backToBack");
        checkOutput("backToBack_fixedRob", {29'd0, cdbRob}, 32'd2);

        // Flush wins over a coinciding issue and grant.
        applyStimulus(1'b1, 8'h10, 32'd1, 32'd2, 32'h600, 32'h18, 32'h18, 3'd7, 1'b1, 1'b1);
        tick("flush");
        checkOutput("flush_fixedReq", {31'd0, cdbReq}, 32'd0);
        idle("afterFlush");

`ifdef BRANCH_STATS_EN
        // Four granted branches, the third mispredicting, with a flush between.
        doReset("statsReset");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 8'h10, 32'd0, 32'd0, 32'h800, 32'h30,
                          (k == 2) ? 32'h30 : 32'h800, 3'(k), 1'b0, 1'b0);
            tick("statsIssue");
            applyStimulus(1'b0, 8'h00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0);
            tick("statsGrant");
            if (k == 1) begin
                applyStimulus(1'b0, 8'h00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1);
                tick("statsFlush");
            end
        end
        checkOutput("stats_fixedBranch", branchCount, 32'd4);
        checkOutput("stats_fixedMisp", mispredictCount, 32'd1);
        doReset("statsClear");
        checkOutput("stats_clearedBranch", branchCount, 32'd0);
        checkOutput("stats_clearedMisp", mispredictCount, 32'd0);
`endif

        // Randomized traffic, never issuing into a busy buffer.
        for (int i = 0; i < 600; i++) begin
            g  = ($urandom_range(0, 2) != 0);
            ex = (!mFull || g) && ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 3))
                0:       info = 8'h00;
                1:       info = 8'h08;
                2:       info = 8'h10;
                default: info = 8'h20;
            endcase
            info[2:0] = 3'($urandom);
            info[7:6] = 2'($urandom);
            a   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) - 32'd4 : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            tgt = $urandom;
            seq = $urandom;
            case ($urandom_range(0, 2))
                0:       pred = seq;
                1:       pred = tgt;
                default: pred = $urandom;
            endcase
            globalReset = ($urandom_range(0, 99) == 0);
            applyStimulus(ex, info, a, b, tgt, seq, pred, 3'($urandom), g, fl);
            tick("rand");
            globalReset = 1'b0;
        end
        idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
